// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and index helper for the 4x4 matrix-multiply sequencer.
package matmul_pkg;
    localparam int DIM   = 4;
    localparam int EW    = 4;
    localparam int PW    = 8;
    localparam int AW    = 10;
    localparam int IW    = 4;
    localparam int RCW   = $clog2(DIM);
    localparam int NELEM = DIM * DIM;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_ACCUM = 3'd3,
        ST_EMIT  = 3'd4
    } state_e;

    // Row-major flat index of element (row, col).
    function automatic logic [IW-1:0] flat_index(input logic [RCW-1:0] row,
                                                 input logic [RCW-1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/operand_bank.sv
// Storage for the A and B operand matrices: one write port, two combinational read ports.
module operand_bank
    import matmul_pkg::*;
(
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_index,
    input  logic [EW-1:0] wr_a,
    input  logic [EW-1:0] wr_b,
    input  logic [IW-1:0] a_index,
    input  logic [IW-1:0] b_index,
    output logic [EW-1:0] a_data,
    output logic [EW-1:0] b_data
);
    logic [EW-1:0] a_mem [NELEM];
    logic [EW-1:0] b_mem [NELEM];

    // Contents are intentionally not reset; they are meaningless until reloaded.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            a_mem[wr_index] <= wr_a;
            b_mem[wr_index] <= wr_b;
        end
    end

    assign a_data = a_mem[a_index];
    assign b_data = b_mem[b_index];
endmodule

// File: rtl/matmul_sequencer.sv
// Loads A and B, steps an external MAC accumulator through the 16 dot products of A*B,
// and streams each finished accumulator value out in row-major order.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*EW-1:0] in_data,
    output logic            mac_clear,
    output logic            mac_ld,
    output logic [PW-1:0]   mac_x,
    input  logic [AW-1:0]   mac_acc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_data,
    output logic [IW-1:0]   out_index,
    output logic            busy
);
    state_e         state_q, state_d;
    logic [IW-1:0]  load_cnt_q, load_cnt_d;
    logic [RCW-1:0] r_q, r_d;
    logic [RCW-1:0] c_q, c_d;
    logic [RCW-1:0] k_q, k_d;

    logic           in_fire;
    logic           out_fire;
    logic [IW-1:0]  elem_index;
    logic [IW-1:0]  a_rd_index;
    logic [IW-1:0]  b_rd_index;
    logic [EW-1:0]  a_op;
    logic [EW-1:0]  b_op;
    logic [PW-1:0]  product;

    assign elem_index = flat_index(r_q, c_q);
    assign a_rd_index = flat_index(r_q, k_q);
    assign b_rd_index = flat_index(k_q, c_q);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign product    = {{(PW-EW){1'b0}}, a_op} * {{(PW-EW){1'b0}}, b_op};

    operand_bank u_bank (
        .clk      (clk),
        .wr_en    (in_fire),
        .wr_index (load_cnt_q),
        .wr_a     (in_data[2*EW-1:EW]),
        .wr_b     (in_data[EW-1:0]),
        .a_index  (a_rd_index),
        .b_index  (b_rd_index),
        .a_data   (a_op),
        .b_data   (b_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    load_cnt_d = IW'(1);
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_fire) begin
                    load_cnt_d = load_cnt_q + IW'(1);
                    if (load_cnt_q == IW'(NELEM - 1)) begin
                        load_cnt_d = '0;
                        r_d        = '0;
                        c_d        = '0;
                        state_d    = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                k_d     = '0;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                k_d = k_q + RCW'(1);
                if (k_q == RCW'(DIM - 1)) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    if (elem_index == IW'(NELEM - 1)) begin
                        r_d     = '0;
                        c_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        // Column wraps into the row because {r, c} is the flat index.
                        {r_d, c_d} = elem_index + IW'(1);
                        state_d    = ST_CLEAR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mac_clear = 1'b0;
        mac_ld    = 1'b0;
        mac_x     = '0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_LOAD: begin
                in_ready  = 1'b1;
                mac_clear = 1'b1;
            end
            ST_CLEAR: mac_clear = 1'b1;
            ST_ACCUM: begin
                mac_ld = 1'b1;
                mac_x  = product;
            end
            ST_EMIT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // The accumulator holds during EMIT, so its output is already a stable result.
    assign out_data  = mac_acc;
    assign out_index = elem_index;
    assign busy      = (state_q != ST_IDLE);
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control and operand stage that sits directly upstream of the MAC accumulator (`mux_mac` plus its 10-bit register). It does three things:
- loads two 4x4 matrices A and B of unsigned 4-bit elements over a valid/ready stream;
- walks the 16 dot products of C = A·B, driving the accumulator's `clear`/`ld` controls and the 8-bit product operand;
- returns each finished 10-bit accumulator value on a valid/ready output stream in row-major order.

## Interface
Parameters:
- none. DIM=4, element width 4, product width 8 and accumulator width 10 are fixed constants from `matmul_pkg`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: load beat valid.
- `in_ready` out 1: load beat accepted when `in_valid & in_ready`.
- `in_data` in 8: `{A[i][j], B[i][j]}`, bits [7:4] = A, [3:0] = B. Beats are row-major, beat n gives i=n/4, j=n%4.
- `mac_clear` out 1: drives the accumulator `clear` input.
- `mac_ld` out 1: drives the accumulator `ld` input.
- `mac_x` out 8: product operand to the accumulator (`x`).
- `mac_acc` in 10: accumulator register output (`y`).
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid & out_ready`.
- `out_data` out 10: C[r][c].
- `out_index` out 4: r*4+c.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD, CLEAR, ACCUM, EMIT.
- IDLE
  - `in_ready`=1, `mac_clear`=1.
  - Accepted beat is stored at index 0 and the state moves to LOAD (beat count = 1).
- LOAD
  - `in_ready`=1, `mac_clear`=1.
  - Each accepted beat is stored at the current count.
  - Accepting beat 15 moves to CLEAR with r=c=0.
  - `in_valid` gaps stall without effect.
- CLEAR
  - `mac_clear`=1, `mac_ld`=0; the accumulator becomes 0 at the next edge.
  - Moves to ACCUM with k=0.
- ACCUM
  - `mac_clear`=0, `mac_ld`=1, `mac_x` = A[r][k]·B[k][c] (unsigned 4x4→8, combinational from stored operands).
  - k increments each cycle; at k=3 the state moves to EMIT.
- EMIT
  - `mac_clear`=0, `mac_ld`=0, so the accumulator holds.
  - `out_valid`=1, `out_data` = `mac_acc` (passed through, stable), `out_index` = r*4+c.
  - On handshake: if index=15, go to IDLE; else advance c (wrapping into r) and go to CLEAR.
- Outputs outside their states: `in_ready` is 0 outside IDLE/LOAD, `out_valid` is 0 outside EMIT, `mac_x` is 0 outside ACCUM.
- Arithmetic: the maximum sum is 4·225 = 900 < 1024, so no overflow or saturation is possible. All values are unsigned.
- Operand storage is written only in IDLE/LOAD and is not cleared by reset (contents are don't-care until reloaded).

## Timing
- Reset values (cycle after `rst` sampled high): state IDLE, `in_ready`=1, `mac_clear`=1, `mac_ld`=0, `mac_x`=0, `out_valid`=0, `out_data` follows `mac_acc` but is gated by `out_valid`=0, `out_index`=0, `busy`=0, counters 0.
- `rst` overrides every state, including mid-LOAD, ACCUM and EMIT. Partially loaded or computed data is discarded and no further `out_valid` is produced.
- Per element: CLEAR 1 cycle + ACCUM 4 cycles + EMIT ≥1 cycle.
- With `out_ready` held high:
  - first `out_valid` appears in the 6th cycle after the edge that accepts beat 15;
  - results follow every 6 cycles;
  - the full matrix takes 96 cycles.
- Backpressure: while `out_ready`=0, `out_valid`, `out_data` and `out_index` hold and the accumulator controls stay 0.
- The edge that completes the final EMIT handshake returns the block to IDLE; `in_ready`=1 in the next cycle. New load beats are never accepted during compute.

## Structure
- `matmul_pkg`: DIM, EW=4, PW=8, AW=10, the state enum, and the index width (4).
- Sub-module `operand_bank`:
  - two 16×4 register arrays;
  - write port: index plus `{a,b}`;
  - two combinational read ports: A[r][k] and B[k][c].
- The sequencer FSM, counters (load count, r, c, k) and the multiplier live in `matmul_sequencer`.

## Test plan
- Bench wiring: a behavioural accumulator, `acc <= clear ? 0 : ld ? acc + x : acc`, fed by `mac_clear`, `mac_ld` and `mac_x`, with its register output driving `mac_acc`.
- Identity test: A = I, B[i][j] = 4i+j, `out_ready`=1 → `out_data` 0..15 with `out_index` 0..15 in order; first `out_valid` 6 cycles after beat 15; `busy` falls after index 15.
- All-max test: A = B = all 15 → all 16 results = 900; `mac_x` = 225 in every ACCUM cycle.
- Backpressure test: `out_ready`=0 for 5 cycles at index 3 → `out_valid` held, `out_data`/`out_index` stable, `mac_ld`=`mac_clear`=0; index 4 follows with no skip or duplicate.
- Load bubbles test: 16 beats with random `in_valid` gaps → only handshaked beats are stored; `in_ready` drops the cycle after beat 15; results match a reference matrix product.
- Reset mid-compute test: assert `rst` during ACCUM of index 5 → next cycle IDLE, `out_valid`=0, `in_ready`=1, `mac_clear`=1; a fresh load produces correct results from index 0.
